// File: rtl/pool_pkg.sv
// Shared constants, types and helpers for the 2x2 stride-2 max-pooling stage.
package pool_pkg;

  localparam int DW       = 16;
  localparam int LINE_W   = 26;
  localparam int POOL_W   = LINE_W / 2;
  localparam int NUM_MAPS = 5;
  localparam int COL_W    = $clog2(LINE_W);
  localparam int MAP_W    = $clog2(NUM_MAPS);
  // pcol is col>>1; with an even LINE_W this needs exactly one bit less than col.
  localparam int PCOL_W   = COL_W - 1;

  localparam logic [COL_W-1:0] POS_LAST = COL_W'(LINE_W - 1);
  localparam logic [MAP_W-1:0] MAP_LAST = MAP_W'(NUM_MAPS - 1);

  typedef logic [DW-1:0] act_t;

  // Unsigned maximum; on a tie both operands are equal so either is correct.
  function automatic act_t umax(input act_t a, input act_t b);
    return (a >= b) ? a : b;
  endfunction

  // Map counter successor, wrapping after the last filter map.
  function automatic logic [MAP_W-1:0] next_map(input logic [MAP_W-1:0] m);
    return (m == MAP_LAST) ? '0 : m + MAP_W'(1);
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// One-row buffer of horizontal pair maxima from the even row of each window.
module pool_line_buf
  import pool_pkg::*;
(
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PCOL_W-1:0] wr_idx,
  input  act_t              wr_data,
  input  logic [PCOL_W-1:0] rd_idx,
  output act_t              rd_data
);

  act_t mem_q [POOL_W];

  // Contents need no reset: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/maxpool_top.sv
// 2x2 stride-2 max pooling over a 26x26 activation map, up to five maps per group.
module maxpool_top
  import pool_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  input  logic          line_start_in,
  input  logic          frame_start_dim_in,
  input  logic          frame_end_dim_in,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          line_start_out,
  output logic          frame_start_out,
  output logic          frame_end_out,
  output logic [2:0]    map_idx,
  output logic          align_err
);

  logic [COL_W-1:0] col_q, col_d, row_q, row_d;
  logic [MAP_W-1:0] map_q, map_d;
  act_t             h_q, h_d;
  logic             align_err_q, align_err_d;
  logic             first_q, first_d;
  logic             out_valid_q, out_valid_d;
  act_t             out_data_q, out_data_d;
  logic             line_start_out_q, line_start_out_d;
  logic             frame_start_out_q, frame_start_out_d;
  logic [2:0]       map_idx_q, map_idx_d;
  logic [1:0]       fe_pipe_q, fe_pipe_d;

  logic [COL_W-1:0]  col_eff, row_eff;
  logic [MAP_W-1:0]  map_eff;
  logic              misalign;
  logic [PCOL_W-1:0] pcol;
  act_t              hmax, win_max, buf_rd_data;
  logic              buf_wr_en;

  // Position the current pixel really occupies after frame-start and line-start realignment.
  always_comb begin
    col_eff  = col_q;
    row_eff  = row_q;
    map_eff  = map_q;
    misalign = 1'b0;
    if (frame_start_dim_in) begin
      col_eff = '0;
      row_eff = '0;
      map_eff = '0;
    end else if (in_valid && line_start_in) begin
      col_eff = '0;
      if (col_q != '0) begin
        misalign = 1'b1;
        if (row_q == POS_LAST) begin
          row_eff = '0;
          map_eff = next_map(map_q);
        end else begin
          row_eff = row_q + COL_W'(1);
        end
      end
    end
  end

  assign pcol      = col_eff[COL_W-1:1];
  assign hmax      = umax(h_q, in_data);
  assign win_max   = umax(hmax, buf_rd_data);
  assign buf_wr_en = in_valid && col_eff[0] && !row_eff[0];

  pool_line_buf u_line_buf (
    .clk     (clk),
    .wr_en   (buf_wr_en),
    .wr_idx  (pcol),
    .wr_data (hmax),
    .rd_idx  (pcol),
    .rd_data (buf_rd_data)
  );

  // Counter advance, horizontal pairing, pooled output and marker generation.
  always_comb begin
    col_d             = col_q;
    row_d             = row_q;
    map_d             = map_q;
    h_d               = h_q;
    align_err_d       = align_err_q;
    first_d           = first_q;
    out_valid_d       = 1'b0;
    out_data_d        = out_data_q;
    line_start_out_d  = 1'b0;
    frame_start_out_d = 1'b0;
    map_idx_d         = map_idx_q;

    if (frame_start_dim_in) begin
      col_d       = '0;
      row_d       = '0;
      map_d       = '0;
      align_err_d = 1'b0;
      first_d     = 1'b1;
    end

    if (in_valid) begin
      if (col_eff == POS_LAST) begin
        col_d = '0;
        if (row_eff == POS_LAST) begin
          row_d = '0;
          map_d = next_map(map_eff);
        end else begin
          row_d = row_eff + COL_W'(1);
          map_d = map_eff;
        end
      end else begin
        col_d = col_eff + COL_W'(1);
        row_d = row_eff;
        map_d = map_eff;
      end

      if (misalign) begin
        align_err_d = 1'b1;
      end

      if (!col_eff[0]) begin
        h_d = in_data;
      end else if (row_eff[0]) begin
        out_valid_d       = 1'b1;
        out_data_d        = win_max;
        line_start_out_d  = (pcol == '0);
        frame_start_out_d = first_q;
        map_idx_d         = 3'(map_eff);
        first_d           = 1'b0;
      end
    end

    if (frame_end_dim_in) begin
      col_d = '0;
      row_d = '0;
      map_d = '0;
      h_d   = '0;
    end

    fe_pipe_d = {fe_pipe_q[0], frame_end_dim_in};
  end

  // State and output registers, all cleared immediately by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q             <= '0;
      row_q             <= '0;
      map_q             <= '0;
      h_q               <= '0;
      align_err_q       <= 1'b0;
      first_q           <= 1'b0;
      out_valid_q       <= 1'b0;
      out_data_q        <= '0;
      line_start_out_q  <= 1'b0;
      frame_start_out_q <= 1'b0;
      map_idx_q         <= '0;
      fe_pipe_q         <= '0;
    end else begin
      col_q             <= col_d;
      row_q             <= row_d;
      map_q             <= map_d;
      h_q               <= h_d;
      align_err_q       <= align_err_d;
      first_q           <= first_d;
      out_valid_q       <= out_valid_d;
      out_data_q        <= out_data_d;
      line_start_out_q  <= line_start_out_d;
      frame_start_out_q <= frame_start_out_d;
      map_idx_q         <= map_idx_d;
      fe_pipe_q         <= fe_pipe_d;
    end
  end

  assign out_valid       = out_valid_q;
  assign out_data        = out_data_q;
  assign line_start_out  = line_start_out_q;
  assign frame_start_out = frame_start_out_q;
  assign frame_end_out   = fe_pipe_q[1];
  assign map_idx         = map_idx_q;
  assign align_err       = align_err_q;

endmodule

// File: tb/tb_maxpool_top.sv
// Directed bench for maxpool_top: windows are modelled from a stored image.
module tb_maxpool_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_data;
  logic        line_start_in;
  logic        frame_start_dim_in;
  logic        frame_end_dim_in;
  logic        out_valid;
  logic [15:0] out_data;
  logic        line_start_out;
  logic        frame_start_out;
  logic        frame_end_out;
  logic [2:0]  map_idx;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  map;
    logic        ls;
    logic        fs;
    longint      t;
  } out_rec_t;

  out_rec_t    exp_q[$];
  out_rec_t    got_q[$];
  longint      fe_exp_q[$];
  longint      fe_got_q[$];
  logic [15:0] img [26][26];
  logic        pending_fs = 1'b0;
  out_rec_t    mon_rec;

  maxpool_top dut (
    .clk                (clk),
    .rst                (rst),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .line_start_in      (line_start_in),
    .frame_start_dim_in (frame_start_dim_in),
    .frame_end_dim_in   (frame_end_dim_in),
    .out_valid          (out_valid),
    .out_data           (out_data),
    .line_start_out     (line_start_out),
    .frame_start_out    (frame_start_out),
    .frame_end_out      (frame_end_out),
    .map_idx            (map_idx),
    .align_err          (align_err)
  );

  always #5 clk = ~clk;

  // Capture every pooled output and frame-end marker away from the rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid) begin
        mon_rec.data = out_data;
        mon_rec.map  = map_idx;
        mon_rec.ls   = line_start_out;
        mon_rec.fs   = frame_start_out;
        mon_rec.t    = $time;
        got_q.push_back(mon_rec);
      end
      if (frame_end_out) fe_got_q.push_back($time);
    end
  end

  function automatic logic [15:0] max4(input logic [15:0] a, b, c, d);
    logic [15:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  task automatic checkOutput(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, expv, expv);
    end
  endtask

  // Drive one pixel for one clock, record the window it completes, then idle for gap cycles.
  task automatic applyStimulus(input int r, input int c, input int m, input logic [15:0] d,
                               input logic ls, input logic fs, input logic fe, input int gap);
    longint   t;
    out_rec_t e;
    in_valid           = 1'b1;
    in_data            = d;
    line_start_in      = ls;
    frame_start_dim_in = fs;
    frame_end_dim_in   = fe;
    @(posedge clk);
    t = $time;
    #1;
    in_valid           = 1'b0;
    line_start_in      = 1'b0;
    frame_start_dim_in = 1'b0;
    frame_end_dim_in   = 1'b0;
    img[r][c] = d;
    if (fs) pending_fs = 1'b1;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      e.data = max4(img[r-1][c-1], img[r-1][c], img[r][c-1], img[r][c]);
      e.map  = 3'(m);
      e.ls   = (c == 1);
      e.fs   = pending_fs;
      e.t    = t + 5;
      exp_q.push_back(e);
      pending_fs = 1'b0;
    end
    if (fe) fe_exp_q.push_back(t + 15);
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  // mode 0: ramp r*26+c; mode 1: random; mode 2: ramp with a fixed top-left window.
  task automatic sendFrame(input int nmaps, input int mode, input int gap);
    logic [15:0] d;
    for (int m = 0; m < nmaps; m++)
      for (int r = 0; r < 26; r++)
        for (int c = 0; c < 26; c++) begin
          d = 16'(r * 26 + c);
          if (mode == 1) d = 16'($urandom);
          if (mode == 2) begin
            if (r == 0 && c == 0) d = 16'h0100;
            if (r == 0 && c == 1) d = 16'hFFFF;
            if (r == 1 && c == 0) d = 16'h0002;
            if (r == 1 && c == 1) d = 16'h8000;
          end
          applyStimulus(r, c, m, d, c == 0, (m == 0 && r == 0 && c == 0),
                        (m == nmaps - 1 && r == 25 && c == 25), gap);
        end
  endtask

  // Let the pipeline drain, compare captured outputs against the model, then clear.
  task automatic verifyOutputs(input string tag);
    int n;
    repeat (6) @(posedge clk);
    #1;
    checkOutput({tag, " count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s data[%0d]", tag, i), got_q[i].data, exp_q[i].data);
      checkOutput($sformatf("%s map[%0d]", tag, i), got_q[i].map, exp_q[i].map);
      checkOutput($sformatf("%s line_start[%0d]", tag, i), got_q[i].ls, exp_q[i].ls);
      checkOutput($sformatf("%s frame_start[%0d]", tag, i), got_q[i].fs, exp_q[i].fs);
      checkOutput($sformatf("%s time[%0d]", tag, i), got_q[i].t, exp_q[i].t);
    end
    checkOutput({tag, " frame_end count"}, fe_got_q.size(), fe_exp_q.size());
    n = (fe_got_q.size() < fe_exp_q.size()) ? fe_got_q.size() : fe_exp_q.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s frame_end time[%0d]", tag, i), fe_got_q[i], fe_exp_q[i]);
  endtask

  task automatic clearQueues();
    exp_q.delete();
    got_q.delete();
    fe_exp_q.delete();
    fe_got_q.delete();
    pending_fs = 1'b0;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " out_valid"}, out_valid, 0);
    checkOutput({tag, " out_data"}, out_data, 0);
    checkOutput({tag, " line_start_out"}, line_start_out, 0);
    checkOutput({tag, " frame_start_out"}, frame_start_out, 0);
    checkOutput({tag, " frame_end_out"}, frame_end_out, 0);
    checkOutput({tag, " map_idx"}, map_idx, 0);
    checkOutput({tag, " align_err"}, align_err, 0);
  endtask

  initial begin
    int ls_cnt, fs_cnt;
    rst                = 1'b1;
    in_valid           = 1'b0;
    in_data            = '0;
    line_start_in      = 1'b0;
    frame_start_dim_in = 1'b0;
    frame_end_dim_in   = 1'b0;
    for (int r = 0; r < 26; r++)
      for (int c = 0; c < 26; c++) img[r][c] = '0;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Single ramp map
    $display("[TB] single map ramp");
    sendFrame(1, 0, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("ramp count", got_q.size(), 169);
    if (got_q.size() == 169) begin
      checkOutput("ramp first", got_q[0].data, 27);
      checkOutput("ramp last", got_q[168].data, 675);
    end
    ls_cnt = 0;
    fs_cnt = 0;
    foreach (got_q[i]) begin
      if (got_q[i].ls) ls_cnt++;
      if (got_q[i].fs) fs_cnt++;
    end
    checkOutput("ramp line_start count", ls_cnt, 13);
    checkOutput("ramp frame_start count", fs_cnt, 1);
    if (got_q.size() > 0) checkOutput("ramp frame_start first", got_q[0].fs, 1);
    verifyOutputs("ramp");
    clearQueues();

    // Unsigned compare on the top-left window
    $display("[TB] unsigned window");
    sendFrame(1, 2, 0);
    repeat (6) @(posedge clk);
    #1;
    if (got_q.size() > 0) checkOutput("unsigned first", got_q[0].data, 16'hFFFF);
    else checkOutput("unsigned first present", 0, 1);
    verifyOutputs("unsigned");
    clearQueues();

    // Five maps back to back, random data, no gaps
    $display("[TB] five maps");
    sendFrame(5, 1, 0);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("five count", got_q.size(), 845);
    if (got_q.size() == 845) begin
      checkOutput("five map first", got_q[0].map, 0);
      checkOutput("five map 169", got_q[169].map, 1);
      checkOutput("five map last", got_q[844].map, 4);
    end
    verifyOutputs("five");
    clearQueues();

    // Gapped input stream
    $display("[TB] gapped ramp");
    sendFrame(1, 0, 1);
    verifyOutputs("gapped");
    clearQueues();

    // Mid-row line_start at row 3 col 10
    $display("[TB] alignment error");
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 26; c++)
        applyStimulus(r, c, 0, 16'($urandom), c == 0, (r == 0 && c == 0), 1'b0, 0);
    for (int c = 0; c < 10; c++)
      applyStimulus(3, c, 0, 16'($urandom), c == 0, 1'b0, 1'b0, 0);
    checkOutput("align_err before", align_err, 0);
    for (int r = 4; r < 26; r++)
      for (int c = 0; c < 26; c++) begin
        applyStimulus(r, c, 0, 16'($urandom), c == 0, 1'b0, (r == 25 && c == 25), 0);
        if (r == 4 && c == 0) checkOutput("align_err set", align_err, 1);
      end
    verifyOutputs("align");
    checkOutput("align_err sticky", align_err, 1);
    clearQueues();
    sendFrame(1, 0, 0);
    checkOutput("align_err cleared", align_err, 0);
    verifyOutputs("after align");
    clearQueues();

    // Reset at row 5 col 7, then a fresh frame
    $display("[TB] reset mid-row");
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 26; c++)
        applyStimulus(r, c, 0, 16'($urandom), c == 0, (r == 0 && c == 0), 1'b0, 0);
    for (int c = 0; c < 7; c++)
      applyStimulus(5, c, 0, 16'($urandom), c == 0, 1'b0, 1'b0, 0);
    verifyOutputs("pre reset");
    clearQueues();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    #1;
    checkResetOutputs("async reset");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkResetOutputs("reset held");
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    sendFrame(1, 1, 0);
    verifyOutputs("post reset");
    clearQueues();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
